// File: rtl/ddc_ctrl_pkg.sv
// Shared types and widths for the DDC/DUC rate-change controllers.
// Default settings addresses mirror the block register map.
package ddc_ctrl_pkg;

    localparam int HB_W   = 2;
    localparam int CIC_W  = 8;
    localparam int RATE_W = 16;
    localparam int SET_AW = 8;
    localparam int SET_DW = 32;

    localparam logic [SET_AW-1:0] DEF_SR_N_ADDR     = 8'd200;
    localparam logic [SET_AW-1:0] DEF_SR_DECIM_ADDR = 8'd201;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FACTOR,
        ST_CHECK,
        ST_ERR,
        ST_WAIT_IDLE,
        ST_WR_N,
        ST_WR_DECIM,
        ST_FLUSH,
        ST_DONE
    } cfg_state_t;

    // SR_DECIM payload: {hb_enables, cic_rate} in the low bits.
    function automatic logic [SET_DW-1:0] decim_word(input logic [HB_W-1:0]  hb,
                                                     input logic [CIC_W-1:0] cic);
        return {22'd0, hb, cic};
    endfunction

endpackage

// File: rtl/ddc_rate_factorizer.sv
// Splits a total rate into half-band stages (factors of two) plus a residual
// CIC rate, and flags residuals outside the legal CIC range.
import ddc_ctrl_pkg::*;

module ddc_rate_factorizer #(
    parameter int NUM_HB   = 3,
    parameter int MAX_RATE = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RATE_W-1:0] rate_in,
    output logic              done,
    output logic              ok,
    output logic [HB_W-1:0]   hb_out,
    output logic [CIC_W-1:0]  cic_out
);

    logic              run;
    logic [RATE_W-1:0] rate_r;
    logic [HB_W-1:0]   hb_r;
    logic              can_shift;

    assign can_shift = ~rate_r[0] && (hb_r < HB_W'(NUM_HB));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run    <= 1'b0;
            rate_r <= '0;
            hb_r   <= '0;
        end else if (start) begin
            run    <= 1'b1;
            rate_r <= rate_in;
            hb_r   <= '0;
        end else if (run) begin
            if (can_shift) begin
                rate_r <= rate_r >> 1;
                hb_r   <= hb_r + 1'b1;
            end else begin
                run <= 1'b0;
            end
        end
    end

    // Results hold after done until the next start.
    assign done    = run & ~can_shift;
    assign ok      = (rate_r != '0) && (rate_r <= RATE_W'(MAX_RATE));
    assign hb_out  = hb_r;
    assign cic_out = rate_r[CIC_W-1:0];

endmodule

// File: rtl/ddc_decim_cfg_ctrl.sv
// Sequences a DDC decimation change: factor, wait for datapath idle, write
// SR_N then SR_DECIM on consecutive cycles, flush filters, report done.
import ddc_ctrl_pkg::*;

module ddc_decim_cfg_ctrl #(
    parameter int                NUM_HB        = 3,
    parameter int                CIC_MAX_DECIM = 255,
    parameter logic [SET_AW-1:0] SR_N_ADDR     = DEF_SR_N_ADDR,
    parameter logic [SET_AW-1:0] SR_DECIM_ADDR = DEF_SR_DECIM_ADDR,
    parameter int                FLUSH_CYCLES  = 16
) (
    input  logic              ce_clk,
    input  logic              ce_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [RATE_W-1:0] req_rate,
    input  logic              dp_idle,
    output logic              set_stb,
    output logic [SET_AW-1:0] set_addr,
    output logic [SET_DW-1:0] set_data,
    output logic              filt_clear,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [HB_W-1:0]   cur_hb,
    output logic [CIC_W-1:0]  cur_cic
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    cfg_state_t        state;
    logic [RATE_W-1:0] req_r;
    logic [FC_W-1:0]   flush_cnt;
    logic              accept;
    logic              fact_done;
    logic              fact_ok;
    logic [HB_W-1:0]   fact_hb;
    logic [CIC_W-1:0]  fact_cic;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;

    ddc_rate_factorizer #(
        .NUM_HB   (NUM_HB),
        .MAX_RATE (CIC_MAX_DECIM)
    ) u_factor (
        .clk     (ce_clk),
        .rst_n   (ce_rst_n),
        .start   (accept),
        .rate_in (req_rate),
        .done    (fact_done),
        .ok      (fact_ok),
        .hb_out  (fact_hb),
        .cic_out (fact_cic)
    );

    always_ff @(posedge ce_clk) begin
        if (!ce_rst_n) begin
            state      <= ST_IDLE;
            req_r      <= '0;
            flush_cnt  <= '0;
            set_stb    <= 1'b0;
            set_addr   <= '0;
            set_data   <= '0;
            filt_clear <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cur_hb     <= '0;
            cur_cic    <= CIC_W'(1);
        end else begin
            set_stb  <= 1'b0;
            set_addr <= '0;
            set_data <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_r <= req_rate;
                        state <= ST_FACTOR;
                    end
                end
                ST_FACTOR: begin
                    if (fact_done) state <= ST_CHECK;
                end
                // With dp_idle already high the wait state is skipped entirely.
                ST_CHECK, ST_WAIT_IDLE: begin
                    if (state == ST_CHECK && !fact_ok) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end else if (dp_idle) begin
                        set_stb  <= 1'b1;
                        set_addr <= SR_N_ADDR;
                        set_data <= SET_DW'(req_r);
                        state    <= ST_WR_N;
                    end else begin
                        state <= ST_WAIT_IDLE;
                    end
                end
                ST_WR_N: begin
                    set_stb  <= 1'b1;
                    set_addr <= SR_DECIM_ADDR;
                    set_data <= decim_word(fact_hb, fact_cic);
                    state    <= ST_WR_DECIM;
                end
                ST_WR_DECIM: begin
                    filt_clear <= 1'b1;
                    flush_cnt  <= FC_W'(FLUSH_CYCLES - 1);
                    state      <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        filt_clear <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    cur_hb  <= fact_hb;
                    cur_cic <= fact_cic;
                    state   <= ST_IDLE;
                end
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddc_decim_cfg_ctrl.sv
// Randomized scoreboard bench for ddc_decim_cfg_ctrl against a rate-arithmetic model.
module tb_ddc_decim_cfg_ctrl;

    localparam int         NUM_HB  = 3;
    localparam int         CIC_MAX = 255;
    localparam int         F       = 4;
    localparam logic [7:0] A_N     = 8'h40;
    localparam logic [7:0] A_D     = 8'h41;

    logic        ce_clk = 1'b0;
    logic        ce_rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_rate = '0;
    logic        dp_idle = 1'b1;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        filt_clear;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  cur_hb;
    logic [7:0]  cur_cic;

    typedef struct {
        bit is_err;
        int rate;
        int hb;
        int cic;
        int ta;
        int stb_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   nstb = 0;
    int   fcnt = 0;
    int   done_seen = 0;
    int   exp_done = 0;
    bit   cur_pend = 0;
    int   cur_hb_e, cur_cic_e;

    ddc_decim_cfg_ctrl #(
        .NUM_HB        (NUM_HB),
        .CIC_MAX_DECIM (CIC_MAX),
        .SR_N_ADDR     (A_N),
        .SR_DECIM_ADDR (A_D),
        .FLUSH_CYCLES  (F)
    ) dut (
        .ce_clk     (ce_clk),
        .ce_rst_n   (ce_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rate   (req_rate),
        .dp_idle    (dp_idle),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .filt_clear (filt_clear),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_hb     (cur_hb),
        .cur_cic    (cur_cic)
    );

    always #5 ce_clk = ~ce_clk;
    always @(posedge ce_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Strip factors of two into half-bands (at most NUM_HB); residual is the CIC rate.
    function automatic void ref_model(input int rate, output int hb, output int cic, output bit bad);
        int r;
        r  = rate;
        hb = 0;
        while (hb < NUM_HB && (r % 2) == 0) begin
            r  = r / 2;
            hb = hb + 1;
        end
        cic = r;
        bad = (r == 0) || (r > CIC_MAX);
    endfunction

    // Monitor / scoreboard
    always @(negedge ce_clk) begin
        if (!ce_rst_n) begin
            q.delete();
            nstb = 0;
            fcnt = 0;
            cur_pend = 0;
        end else begin
            if (cur_pend) begin
                chk("cur_hb", cur_hb, cur_hb_e);
                chk("cur_cic", cur_cic, cur_cic_e);
                cur_pend = 0;
            end
            if (!set_stb && (set_addr != 0 || set_data != 0)) chk("bus_zero_when_idle", 1, 0);
            if (filt_clear) fcnt++;
            if (set_stb) begin
                if (q.size() == 0 || q[0].is_err || nstb > 1) chk("unexpected_stb", 1, 0);
                else if (nstb == 0) begin
                    chk("wr_n_addr", set_addr, A_N);
                    chk("wr_n_data", set_data, q[0].rate);
                    chk("wr_n_cycle", cyc, q[0].stb_cyc);
                    chk("busy_at_wr", busy, 1);
                    nstb = 1;
                end else begin
                    chk("wr_decim_addr", set_addr, A_D);
                    chk("wr_decim_data", set_data, q[0].hb * 256 + q[0].cic);
                    chk("wr_decim_cycle", cyc, q[0].stb_cyc + 1);
                    nstb = 2;
                end
            end
            if (done) begin
                done_seen++;
                if (q.size() == 0 || q[0].is_err) chk("unexpected_done", 1, 0);
                else begin
                    chk("done_cycle", cyc, q[0].stb_cyc + 2 + F);
                    chk("flush_len", fcnt, F);
                    chk("writes_before_done", nstb, 2);
                    cur_hb_e  = q[0].hb;
                    cur_cic_e = q[0].cic;
                    cur_pend  = 1;
                    void'(q.pop_front());
                end
                nstb = 0;
                fcnt = 0;
            end
            if (err) begin
                if (q.size() == 0 || !q[0].is_err) chk("unexpected_err", 1, 0);
                else begin
                    chk("err_cycle", cyc, q[0].ta + q[0].hb + 3);
                    chk("no_write_on_err", nstb, 0);
                    void'(q.pop_front());
                end
                nstb = 0;
                fcnt = 0;
            end
        end
    end

    task automatic wait_quiet();
        int g;
        g = 0;
        while ((q.size() != 0 || !req_ready) && g < 600) begin
            @(negedge ce_clk);
            g++;
        end
        if (g >= 600) chk("completion_timeout", 0, 1);
        @(negedge ce_clk);
    endtask

    // d < 0: dp_idle stays high; else dp_idle low until d cycles after CHECK.
    task automatic issue(input int rate, input int d, input bit hold, input bit wait_end);
        exp_t e;
        int   hb, cic, g;
        bit   bad;
        g = 0;
        while (!req_ready && g < 1000) begin
            @(negedge ce_clk);
            g++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        ref_model(rate, hb, cic, bad);
        e.is_err  = bad;
        e.rate    = rate;
        e.hb      = hb;
        e.cic     = cic;
        e.ta      = cyc;
        e.stb_cyc = (d < 0) ? cyc + hb + 3 : cyc + hb + 3 + d;
        if (!bad) exp_done++;
        q.push_back(e);
        if (d >= 0) dp_idle = 1'b0;
        req_valid = 1'b1;
        req_rate  = 16'(rate);
        @(negedge ce_clk);
        if (hold) begin
            req_rate = 16'd7;
            repeat (6) @(negedge ce_clk);
        end
        req_valid = 1'b0;
        if (d >= 0) begin
            while (cyc < e.ta + hb + 2 + d) @(negedge ce_clk);
            if (!bad) begin
                chk("busy_while_waiting", busy, 1);
                chk("no_stb_while_waiting", set_stb, 0);
            end
            dp_idle = 1'b1;
        end
        if (wait_end) wait_quiet();
    endtask

    initial begin
        int rate, d, g;
        repeat (3) @(negedge ce_clk);
        @(posedge ce_clk);
        #1 ce_rst_n = 1'b1;
        @(negedge ce_clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_set_stb", set_stb, 0);
        chk("rst_filt_clear", filt_clear, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cur_hb", cur_hb, 0);
        chk("rst_cur_cic", cur_cic, 1);

        issue(8, -1, 0, 1);
        issue(40, -1, 0, 1);
        issue(13, -1, 0, 1);
        issue(1, -1, 0, 1);
        issue(2048, -1, 0, 1);
        issue(0, -1, 0, 1);
        issue(12, 100, 0, 1);
        issue(24, -1, 1, 1);

        // Reset during FLUSH
        issue(40, -1, 0, 1);
        issue(12, -1, 0, 0);
        g = 0;
        while (!filt_clear && g < 100) begin
            @(negedge ce_clk);
            g++;
        end
        chk("flush_reached", filt_clear, 1);
        @(negedge ce_clk);
        ce_rst_n = 1'b0;
        @(negedge ce_clk);
        chk("midrst_filt_clear", filt_clear, 0);
        chk("midrst_cur_hb", cur_hb, 0);
        chk("midrst_cur_cic", cur_cic, 1);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_done", done, 0);
        @(posedge ce_clk);
        #1 ce_rst_n = 1'b1;
        exp_done--;
        repeat (30) @(negedge ce_clk);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 9))
                0:       rate = 0;
                1:       rate = int'($urandom_range(256, 65535));
                default: rate = int'($urandom_range(1, 255)) << $urandom_range(0, 4);
            endcase
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            issue(rate, d, 0, 1);
        end

        chk("done_count", done_seen, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
